// File: rtl/spin_sequencer.sv
// Game-round sequencer: spins three reels for a tick budget, stops them in turn,
// pulses compute once per round and counts completed rounds (saturating).
// Optional STOP_BTN_EN: player may cut SPIN short once at least one tick is counted.
module spin_sequencer #(
  parameter int SPIN_TICKS    = 8,
  parameter int STAGGER_TICKS = 4,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       run_game,
  input  logic       stop_btn,
  output logic       hold,
  output logic       compute,
  output logic [2:0] reel_stop,
  output logic       spinning,
  output logic [7:0] games_played
);

  typedef enum logic [2:0] {
    IDLE, SPIN, STOP1, STOP2, STOP3, SETTLE, WAIT_CLR
  } state_t;

  // Comparing against the last count value lets the terminal tick leave directly
  localparam logic [CNT_W-1:0] SPIN_LAST    = CNT_W'(SPIN_TICKS - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_TICKS - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             hold_nx, compute_nx, spinning_nx;
  logic [2:0]       reel_stop_nx;
  logic [7:0]       games_nx;

`ifndef STOP_BTN_EN
  logic unused_stop_btn;
  assign unused_stop_btn = stop_btn;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      hold         <= 1'b0;
      compute      <= 1'b0;
      reel_stop    <= '0;
      spinning     <= 1'b0;
      games_played <= '0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      hold         <= hold_nx;
      compute      <= compute_nx;
      reel_stop    <= reel_stop_nx;
      spinning     <= spinning_nx;
      games_played <= games_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    hold_nx      = hold;
    compute_nx   = 1'b0;
    reel_stop_nx = reel_stop;
    spinning_nx  = spinning;
    games_nx     = games_played;
    case (state)
      IDLE: begin
        if (run_game) begin
          state_nx    = SPIN;
          hold_nx     = 1'b1;
          spinning_nx = 1'b1;
          cnt_nx      = '0;
        end
      end
      SPIN: begin
        if (tick) begin
          if (cnt == SPIN_LAST) begin
            state_nx     = STOP1;
            reel_stop_nx = 3'b001;
            cnt_nx       = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
`ifdef STOP_BTN_EN
        if (stop_btn && cnt != '0) begin
          state_nx     = STOP1;
          reel_stop_nx = 3'b001;
          cnt_nx       = '0;
        end
`endif
      end
      STOP1: begin
        if (tick) begin
          if (cnt == STAGGER_LAST) begin
            state_nx     = STOP2;
            reel_stop_nx = 3'b011;
            cnt_nx       = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      STOP2: begin
        if (tick) begin
          if (cnt == STAGGER_LAST) begin
            state_nx     = STOP3;
            reel_stop_nx = 3'b111;
            spinning_nx  = 1'b0;
            cnt_nx       = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      STOP3: state_nx = SETTLE;
      SETTLE: begin
        compute_nx = 1'b1;
        if (games_played != 8'hFF) games_nx = games_played + 8'd1;
        state_nx = WAIT_CLR;
      end
      WAIT_CLR: begin
        if (!run_game) begin
          state_nx     = IDLE;
          hold_nx      = 1'b0;
          reel_stop_nx = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spin_sequencer.sv
// Directed bench for spin_sequencer: checkpoint tables per round, tick every 4th clk.
// Expectations for the early-stop round follow STOP_BTN_EN when it is defined.
module tb_spin_sequencer;

  logic       clk = 1'b0;
  logic       reset, tick, run_game, stop_btn;
  logic       hold, compute, spinning;
  logic [2:0] reel_stop;
  logic [7:0] games_played;

  int checks = 0;
  int errors = 0;
  int viol   = 0;

  typedef struct {
    int         step;
    logic       hold;
    logic [2:0] rs;
    logic       spin;
    logic       comp;
    logic [7:0] games;
  } vec_t;

  vec_t tbl[$];

  spin_sequencer #(.SPIN_TICKS(8), .STAGGER_TICKS(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .tick(tick), .run_game(run_game), .stop_btn(stop_btn),
    .hold(hold), .compute(compute), .reel_stop(reel_stop), .spinning(spinning),
    .games_played(games_played)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (compute === 1'b1 && hold !== 1'b1) viol++;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input int step, input logic h, input logic [2:0] r, input logic s,
                     input logic c, input logic [7:0] g);
    vec_t v;
    v.step = step; v.hold = h; v.rs = r; v.spin = s; v.comp = c; v.games = g;
    tbl.push_back(v);
  endtask

  task automatic check_outs(input string tag, input logic h, input logic [2:0] r,
                            input logic s, input logic c, input logic [7:0] g);
    check({tag, " hold"}, 32'(hold), 32'(h));
    check({tag, " reel_stop"}, 32'(reel_stop), 32'(r));
    check({tag, " spinning"}, 32'(spinning), 32'(s));
    check({tag, " compute"}, 32'(compute), 32'(c));
    check({tag, " games"}, 32'(games_played), 32'(g));
  endtask

  // Step s: inputs applied, one clock, outputs sampled 1 time unit after the edge
  task automatic run_round(input string tag, input int n_steps, input int drop_step,
                           input int stop_step, input int reset_step, input int exp_pulses);
    int pulses = 0;
    for (int s = 0; s < n_steps; s++) begin
      run_game = (s < drop_step);
      stop_btn = (s == stop_step);
      reset    = (s == reset_step);
      tick     = (s != 0) && (s % 4 == 0);
      @(posedge clk); #1;
      if (compute === 1'b1) pulses++;
      foreach (tbl[i]) begin
        if (tbl[i].step == s)
          check_outs($sformatf("%s s%0d", tag, s), tbl[i].hold, tbl[i].rs, tbl[i].spin,
                     tbl[i].comp, tbl[i].games);
      end
    end
    reset = 1'b0; stop_btn = 1'b0; tick = 1'b0; run_game = 1'b0;
    check({tag, " compute_pulses"}, 32'(pulses), 32'(exp_pulses));
    tbl.delete();
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; run_game = 1'b0; stop_btn = 1'b0;

    // Reset and idle hold
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 1'b0, 3'b000, 1'b0, 1'b0, 8'd0);
    reset = 1'b0;
    repeat (5) begin
      tick = ~tick;
      @(posedge clk); #1;
    end
    tick = 1'b0;
    check_outs("idle", 1'b0, 3'b000, 1'b0, 1'b0, 8'd0);

    // Full round, run_game kept high 20 clks past compute, then dropped
    add(0,  1, 3'b000, 1, 0, 0);
    add(31, 1, 3'b000, 1, 0, 0);
    add(32, 1, 3'b001, 1, 0, 0);
    add(47, 1, 3'b001, 1, 0, 0);
    add(48, 1, 3'b011, 1, 0, 0);
    add(63, 1, 3'b011, 1, 0, 0);
    add(64, 1, 3'b111, 0, 0, 0);
    add(65, 1, 3'b111, 0, 0, 0);
    add(66, 1, 3'b111, 0, 1, 1);
    add(67, 1, 3'b111, 0, 0, 1);
    add(86, 1, 3'b111, 0, 0, 1);
    add(87, 0, 3'b000, 0, 0, 1);
    run_round("round", 88, 87, -1, -1, 1);

    // Reset during STOP2 (reel_stop=011), then run_game low stays idle
    add(0,  1, 3'b000, 1, 0, 1);
    add(48, 1, 3'b011, 1, 0, 1);
    add(50, 0, 3'b000, 0, 0, 0);
    add(52, 0, 3'b000, 0, 0, 0);
    run_round("rst_mid", 53, 51, -1, 50, 0);

    // Stop button pressed with cnt==2 in SPIN
`ifdef STOP_BTN_EN
    add(8,  1, 3'b000, 1, 0, 0);
    add(9,  1, 3'b001, 1, 0, 0);
    add(23, 1, 3'b001, 1, 0, 0);
    add(24, 1, 3'b011, 1, 0, 0);
    add(40, 1, 3'b111, 0, 0, 0);
    add(41, 1, 3'b111, 0, 0, 0);
    add(42, 1, 3'b111, 0, 1, 1);
    add(43, 1, 3'b111, 0, 0, 1);
    add(45, 0, 3'b000, 0, 0, 1);
    run_round("stop_btn", 46, 44, 9, -1, 1);
`else
    add(9,  1, 3'b000, 1, 0, 0);
    add(32, 1, 3'b001, 1, 0, 0);
    add(64, 1, 3'b111, 0, 0, 0);
    add(66, 1, 3'b111, 0, 1, 1);
    add(67, 1, 3'b111, 0, 0, 1);
    add(69, 0, 3'b000, 0, 0, 1);
    run_round("stop_btn", 70, 68, 9, -1, 1);
`endif

    // Saturation over 256 back-to-back rounds
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("sat start games", 32'(games_played), 32'd0);
    for (int r = 1; r <= 256; r++) begin
      run_round($sformatf("sat r%0d", r), 68, 67, -1, -1, 1);
      if (r == 1)   check("sat games r1",   32'(games_played), 32'd1);
      if (r == 254) check("sat games r254", 32'(games_played), 32'd254);
      if (r == 255) check("sat games r255", 32'(games_played), 32'd255);
      if (r == 256) check("sat games r256", 32'(games_played), 32'd255);
    end

    check("compute_while_hold_low", 32'(viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
